msdf_operand_serializer: RTL and testbench
==========================================

// Module: msdf_operand_serializer
// PURPOSE
//  Transmit end of the MSDF mbus write channel: accepts a pair of parallel two's-complement fractions,
//  converts each to a most-significant-digit-first signed-digit stream, drives wen/wvalid/wlast/wdata_x/y
//  straight into an online operator (adder/multiplier interface). One frame = ACCURATE_SET digit cycles.
// PARAMETERS
//  RADIX_MODE     8'd1            radix 2**RADIX_MODE; only 1 (radix-2) supported, other values -> elaboration error
//  ENCODING_MODE  "signed-digit"  digit code: "signed-digit" (+1=2'b10, -1=2'b01, 0=2'b00) or "borrow-save" (2-bit signed -1/0/+1)
//  DATA_WIDTH     8'd2            digit width on mbus; must be 2
//  ACCURATE_SET   8'd8            digits per frame N; operand width N+1 (sign + N fraction bits)
// PORTS
//  i_clk            in   1        clock
//  i_rstn           in   1        reset, synchronous, active-low
//  i_load_valid     in   1        operand pair valid
//  o_load_ready     out  1        serializer can accept a pair
//  i_load_x         in   N+1      operand X, two's complement, weight of bit N = -1
//  i_load_y         in   N+1      operand Y, same format
//  o_mbus_wen       out  1        write enable, high for every digit of a frame
//  o_mbus_wdata_x   out  2        digit of X
//  o_mbus_wdata_y   out  2        digit of Y
//  o_mbus_wvalid    out  1        digit valid
//  o_mbus_wlast     out  1        last (N-th) digit of frame
//  o_sat            out  1        sticky: current/last frame had an operand saturated
// BEHAVIOUR
//  Reset (i_rstn=0 at posedge): all outputs 0 except o_load_ready=1; state IDLE; counter 0. Reset mid-frame
//   aborts the frame, no wlast issued.
//  FSM: IDLE -> SEND on accept (i_load_valid & o_load_ready); SEND -> GAP after digit N; GAP -> IDLE next cycle.
//  o_load_ready = 1 only in IDLE (macro below extends it). i_load_x/y sampled only on accept.
//  Conversion on accept: sign s=msb, magnitude m = s ? -x : x (N fraction bits). Input 1.00..0 (=-1) saturates:
//   m = all ones (value -(1-2^-N)), o_sat set. o_sat cleared on next accept unless that pair saturates too.
//  Digit k (k=1..N, weight 2^-k) = s ? -m[N-k] : m[N-k]; exact, every digit in {-1,0,+1}.
//  Latency: accept at cycle t -> digit 1 at t+1, digit k at t+k, wlast with digit N at t+N. Outputs registered.
//  wen=wvalid=1 for exactly N consecutive cycles; wdata_x/y=0 and wen/wvalid/wlast=0 outside frames.
//  No backpressure on mbus: once started a frame always completes (only reset stops it).
//  Digit counter width clog2(N+1); terminal count N, no wrap beyond.
//  N=1: single-cycle frame, wvalid and wlast same cycle.
// CONFIGURATION
//  MSDF_SER_BACK2BACK_EN defined: GAP state removed; o_load_ready also high during digit N cycle; accept there
//   makes digit 1 of next frame follow wlast with zero idle cycles.
//  Not defined: one idle cycle (GAP, wen=0) between frames; o_load_ready low during SEND and GAP.
// STRUCTURE
//  Package msdf_pkg: digit code localparams (SD_POS/SD_NEG/SD_ZERO, BS_*), FSM state encoding, encode helper.
//  Sub-module msdf_digit_encoder: combinational {sign,bit} -> 2-bit digit per ENCODING_MODE; one instance per operand.
//  Top: accept logic, magnitude/saturation, two N-bit left-shift registers, digit counter, FSM, output regs.
// TESTING
//  1 x=9'b0_1011_0010, y=0, SD -> wdata_x 10,00,10,10,00,00,10,00; y all 00; wlast on 8th; o_sat=0.
//  2 x=9'b1_1100_0000 (-0.25), y=9'b0_1000_0000, SD -> x 00,01,00..00; y 10,00..00; BS mode x 00,11,00..00.
//  3 x=9'b1_0000_0000 (-1) -> x all eight digits 01, o_sat=1; next accept with x=0 clears o_sat.
//  4 i_load_valid held high for 3 frames -> o_load_ready=0 during SEND; without macro 1 idle cycle between
//    frames (period 9), with MSDF_SER_BACK2BACK_EN period 8, no idle cycle.
//  5 i_rstn=0 at digit 4 -> next cycle all mbus outputs 0, no wlast, o_load_ready=1; new frame starts clean.
//  6 Loopback into OnTheFly_Adder_Interface, 1000 random pairs -> adder output digits equal x+y reference.

Source files
------------

// File: rtl/msdf_pkg.sv
// ============================================================================
// Module      : msdf_pkg
// Description : Shared digit codes, serializer FSM encoding and digit encode helper.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package msdf_pkg;

    localparam logic [1:0] SD_POS  = 2'b10;
    localparam logic [1:0] SD_NEG  = 2'b01;
    localparam logic [1:0] SD_ZERO = 2'b00;

    localparam logic [1:0] BS_POS  = 2'b01;
    localparam logic [1:0] BS_NEG  = 2'b11;
    localparam logic [1:0] BS_ZERO = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } ser_state_t;

    // A set magnitude bit becomes +1 or -1 depending on the operand sign.
    function automatic logic [1:0] encode_digit(
        input logic bs_mode,
        input logic sign,
        input logic mag_bit
    );
        logic [1:0] code;
        if (!mag_bit)
            code = bs_mode ? BS_ZERO : SD_ZERO;
        else if (bs_mode)
            code = sign ? BS_NEG : BS_POS;
        else
            code = sign ? SD_NEG : SD_POS;
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/msdf_digit_encoder.sv
// ============================================================================
// Module      : msdf_digit_encoder
// Description : Combinational {sign, magnitude bit} -> 2-bit signed digit code.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module msdf_digit_encoder
    import msdf_pkg::*;
#(
    parameter string ENCODING_MODE = "signed-digit"
) (
    input  logic       i_sign,
    input  logic       i_bit,
    output logic [1:0] o_digit
);

    localparam bit BS_MODE = (ENCODING_MODE == "borrow-save");

    assign o_digit = encode_digit(BS_MODE, i_sign, i_bit);

endmodule

`default_nettype wire

// File: rtl/msdf_operand_serializer.sv
// ============================================================================
// Module      : msdf_operand_serializer
// Description : Parallel fraction pair -> MSDF signed-digit mbus write frames.
//               Define MSDF_SER_BACK2BACK_EN to drop the inter-frame idle cycle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module msdf_operand_serializer
    import msdf_pkg::*;
#(
    parameter logic [7:0] RADIX_MODE    = 8'd1,
    parameter string      ENCODING_MODE = "signed-digit",
    parameter logic [7:0] DATA_WIDTH    = 8'd2,
    parameter logic [7:0] ACCURATE_SET  = 8'd8
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_load_valid,
    output logic                  o_load_ready,
    input  logic [ACCURATE_SET:0] i_load_x,
    input  logic [ACCURATE_SET:0] i_load_y,
    output logic                  o_mbus_wen,
    output logic [1:0]            o_mbus_wdata_x,
    output logic [1:0]            o_mbus_wdata_y,
    output logic                  o_mbus_wvalid,
    output logic                  o_mbus_wlast,
    output logic                  o_sat
);

    localparam int N     = int'(ACCURATE_SET);
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N);

`ifdef MSDF_SER_BACK2BACK_EN
    localparam bit         B2B          = 1'b1;
    localparam ser_state_t ST_FRAME_END = ST_IDLE;
`else
    localparam bit         B2B          = 1'b0;
    localparam ser_state_t ST_FRAME_END = ST_GAP;
`endif

    generate
        if (RADIX_MODE != 8'd1) begin : g_bad_radix
            $error("msdf_operand_serializer: only RADIX_MODE 1 is supported");
        end
        if (DATA_WIDTH != 8'd2) begin : g_bad_width
            $error("msdf_operand_serializer: DATA_WIDTH must be 2");
        end
        if (ACCURATE_SET == 8'd0) begin : g_bad_n
            $error("msdf_operand_serializer: ACCURATE_SET must be at least 1");
        end
        if (ENCODING_MODE != "signed-digit" && ENCODING_MODE != "borrow-save") begin : g_bad_enc
            $error("msdf_operand_serializer: unknown ENCODING_MODE");
        end
    endgenerate

    ser_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_load_ready;
    logic [N-1:0]     r_sh_x, r_sh_y;
    logic             r_sign_x, r_sign_y;
    logic             r_wen, r_wvalid, r_wlast, r_sat;
    logic [1:0]       r_wdata_x, r_wdata_y;

    logic             w_accept;
    logic [N-1:0]     w_neg_x, w_neg_y, w_mag_x, w_mag_y;
    logic             w_sat_x, w_sat_y;
    logic             w_enc_sign_x, w_enc_sign_y, w_enc_bit_x, w_enc_bit_y;
    logic [1:0]       w_digit_x, w_digit_y;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_accept = i_load_valid & r_load_ready;

    // -1 has no positive counterpart; clamp its magnitude to all ones.
    assign w_neg_x = ~i_load_x[N-1:0] + N'(1);
    assign w_neg_y = ~i_load_y[N-1:0] + N'(1);
    assign w_sat_x = i_load_x[N] & ~(|i_load_x[N-1:0]);
    assign w_sat_y = i_load_y[N] & ~(|i_load_y[N-1:0]);
    assign w_mag_x = w_sat_x ? {N{1'b1}} : (i_load_x[N] ? w_neg_x : i_load_x[N-1:0]);
    assign w_mag_y = w_sat_y ? {N{1'b1}} : (i_load_y[N] ? w_neg_y : i_load_y[N-1:0]);

    // Digit 1 comes straight from the incoming operand, later digits from the shifters.
    assign w_enc_sign_x = w_accept ? i_load_x[N]    : r_sign_x;
    assign w_enc_sign_y = w_accept ? i_load_y[N]    : r_sign_y;
    assign w_enc_bit_x  = w_accept ? w_mag_x[N-1]   : r_sh_x[N-1];
    assign w_enc_bit_y  = w_accept ? w_mag_y[N-1]   : r_sh_y[N-1];

    assign w_cnt_nxt = r_cnt + CNT_ONE;

    msdf_digit_encoder #(.ENCODING_MODE(ENCODING_MODE)) u_enc_x (
        .i_sign  (w_enc_sign_x),
        .i_bit   (w_enc_bit_x),
        .o_digit (w_digit_x)
    );

    msdf_digit_encoder #(.ENCODING_MODE(ENCODING_MODE)) u_enc_y (
        .i_sign  (w_enc_sign_y),
        .i_bit   (w_enc_bit_y),
        .o_digit (w_digit_y)
    );

    // The state leads the registered outputs: it leaves SEND on the edge
    // that registers digit N, so GAP coincides with the wlast cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_load_ready <= 1'b1;
            r_sh_x       <= '0;
            r_sh_y       <= '0;
            r_sign_x     <= 1'b0;
            r_sign_y     <= 1'b0;
            r_wen        <= 1'b0;
            r_wvalid     <= 1'b0;
            r_wlast      <= 1'b0;
            r_wdata_x    <= 2'b00;
            r_wdata_y    <= 2'b00;
            r_sat        <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= CNT_ONE;
            r_sh_x    <= w_mag_x << 1;
            r_sh_y    <= w_mag_y << 1;
            r_sign_x  <= i_load_x[N];
            r_sign_y  <= i_load_y[N];
            r_sat     <= w_sat_x | w_sat_y;
            r_wen     <= 1'b1;
            r_wvalid  <= 1'b1;
            r_wlast   <= (N == 1);
            r_wdata_x <= w_digit_x;
            r_wdata_y <= w_digit_y;
            if (N == 1) begin
                r_state      <= ST_FRAME_END;
                r_load_ready <= B2B;
            end else begin
                r_state      <= ST_SEND;
                r_load_ready <= 1'b0;
            end
        end else begin
            case (r_state)
                ST_SEND: begin
                    r_cnt     <= w_cnt_nxt;
                    r_sh_x    <= r_sh_x << 1;
                    r_sh_y    <= r_sh_y << 1;
                    r_wdata_x <= w_digit_x;
                    r_wdata_y <= w_digit_y;
                    r_wlast   <= (w_cnt_nxt == CNT_LAST);
                    if (w_cnt_nxt == CNT_LAST) begin
                        r_state      <= ST_FRAME_END;
                        r_load_ready <= B2B;
                    end
                end
`ifndef MSDF_SER_BACK2BACK_EN
                ST_GAP: begin
                    r_state      <= ST_IDLE;
                    r_load_ready <= 1'b1;
                    r_wen        <= 1'b0;
                    r_wvalid     <= 1'b0;
                    r_wlast      <= 1'b0;
                    r_wdata_x    <= 2'b00;
                    r_wdata_y    <= 2'b00;
                end
`endif
                default: begin
                    r_state      <= ST_IDLE;
                    r_load_ready <= 1'b1;
                    r_wen        <= 1'b0;
                    r_wvalid     <= 1'b0;
                    r_wlast      <= 1'b0;
                    r_wdata_x    <= 2'b00;
                    r_wdata_y    <= 2'b00;
                end
            endcase
        end
    end

    assign o_load_ready   = r_load_ready;
    assign o_mbus_wen     = r_wen;
    assign o_mbus_wvalid  = r_wvalid;
    assign o_mbus_wlast   = r_wlast;
    assign o_mbus_wdata_x = r_wdata_x;
    assign o_mbus_wdata_y = r_wdata_y;
    assign o_sat          = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_msdf_operand_serializer.sv
// ============================================================================
// Module      : tb_msdf_operand_serializer
// Description : Scoreboard bench for msdf_operand_serializer (signed-digit and borrow-save).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_msdf_operand_serializer;

    typedef struct packed {
        logic [1:0] dx;
        logic [1:0] dy;
        logic       last;
        logic       sat;
    } exp_t;

`ifdef MSDF_SER_BACK2BACK_EN
    localparam bit B2B    = 1'b1;
    localparam int PERIOD = 8;
`else
    localparam bit B2B    = 1'b0;
    localparam int PERIOD = 9;
`endif

    logic       i_clk = 1'b0;
    logic       i_rstn;
    logic       i_load_valid;
    logic [8:0] i_load_x, i_load_y;
    logic       o_load_ready, o_wen, o_wvalid, o_wlast, o_sat;
    logic [1:0] o_wdata_x, o_wdata_y;
    logic       b_load_ready, b_wen, b_wvalid, b_wlast, b_sat;
    logic [1:0] b_wdata_x, b_wdata_y;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    logic [8:0]  vx[7], vy[7];
    logic [15:0] ex[7], ey[7];
    logic        vs[7];

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    msdf_operand_serializer dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_load_valid(i_load_valid), .o_load_ready(o_load_ready),
        .i_load_x(i_load_x), .i_load_y(i_load_y), .o_mbus_wen(o_wen),
        .o_mbus_wdata_x(o_wdata_x), .o_mbus_wdata_y(o_wdata_y), .o_mbus_wvalid(o_wvalid),
        .o_mbus_wlast(o_wlast), .o_sat(o_sat)
    );

    msdf_operand_serializer #(.ENCODING_MODE("borrow-save")) dut_bs (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_load_valid(i_load_valid), .o_load_ready(b_load_ready),
        .i_load_x(i_load_x), .i_load_y(i_load_y), .o_mbus_wen(b_wen),
        .o_mbus_wdata_x(b_wdata_x), .o_mbus_wdata_y(b_wdata_y), .o_mbus_wvalid(b_wvalid),
        .o_mbus_wlast(b_wlast), .o_sat(b_sat)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] sd2bs(input logic [1:0] sd);
        case (sd)
            2'b10:   return 2'b01;
            2'b01:   return 2'b11;
            2'b00:   return 2'b00;
            default: return 2'bxx;
        endcase
    endfunction

    task automatic push_frame(input int idx);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            e.dx   = ex[idx][15-2*k -: 2];
            e.dy   = ey[idx][15-2*k -: 2];
            e.last = (k == 7);
            e.sat  = vs[idx];
            sb.push_back(e);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int idx, output int acc_cyc);
        int n;
        i_load_x     = vx[idx];
        i_load_y     = vy[idx];
        i_load_valid = 1'b1;
        push_frame(idx);
        n = 0;
        while (!o_load_ready && n < 40) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_load_ready) begin
            errors++;
            $display("FAIL accept_timeout vector=%0d actual=ready_low required=ready_high", idx);
            acc_cyc = -1;
        end else begin
            @(posedge i_clk);
            acc_cyc = cyc;
            @(negedge i_clk);
            chk("first_digit_latency", {15'd0, o_wvalid}, 16'd1);
        end
    endtask

    // Monitor: every digit the DUT presents is matched against the scoreboard.
    always @(posedge i_clk) begin
        exp_t e;
        #1;
        if (i_rstn) begin
            chk("wen_eq_wvalid", {15'd0, o_wen}, {15'd0, o_wvalid});
            chk("bs_wvalid", {15'd0, b_wvalid}, {15'd0, o_wvalid});
            if (o_wvalid) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_digit actual=%b%b required=none", o_wdata_x, o_wdata_y);
                end else begin
                    e = sb.pop_front();
                    chk("digit_x", {14'd0, o_wdata_x}, {14'd0, e.dx});
                    chk("digit_y", {14'd0, o_wdata_y}, {14'd0, e.dy});
                    chk("bs_digit_x", {14'd0, b_wdata_x}, {14'd0, sd2bs(e.dx)});
                    chk("bs_digit_y", {14'd0, b_wdata_y}, {14'd0, sd2bs(e.dy)});
                    chk("wlast", {15'd0, o_wlast}, {15'd0, e.last});
                    chk("sat", {15'd0, o_sat}, {15'd0, e.sat});
                    chk("ready_in_frame", {15'd0, o_load_ready}, {15'd0, B2B & e.last});
                end
            end else begin
                chk("idle_outputs", {11'd0, o_wlast, o_wdata_x, o_wdata_y}, 16'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2;
        vx[0] = 9'b0_1011_0010; vy[0] = 9'b0_0000_0000; ex[0] = 16'b10_00_10_10_00_00_10_00; ey[0] = 16'h0000; vs[0] = 1'b0;
        vx[1] = 9'b1_1100_0000; vy[1] = 9'b0_1000_0000; ex[1] = 16'b00_01_00_00_00_00_00_00; ey[1] = 16'b10_00_00_00_00_00_00_00; vs[1] = 1'b0;
        vx[2] = 9'b1_0000_0000; vy[2] = 9'b0_0000_0000; ex[2] = 16'h5555; ey[2] = 16'h0000; vs[2] = 1'b1;
        vx[3] = 9'b0_0000_0000; vy[3] = 9'b0_0000_0000; ex[3] = 16'h0000; ey[3] = 16'h0000; vs[3] = 1'b0;
        vx[4] = 9'b0_1111_1111; vy[4] = 9'b1_0000_0001; ex[4] = 16'hAAAA; ey[4] = 16'h5555; vs[4] = 1'b0;
        vx[5] = 9'b1_1111_1111; vy[5] = 9'b1_0000_0000; ex[5] = 16'h0001; ey[5] = 16'h5555; vs[5] = 1'b1;
        vx[6] = 9'b0_0000_0001; vy[6] = 9'b1_0101_0101; ex[6] = 16'h0002; ey[6] = 16'h4445; vs[6] = 1'b0;

        i_rstn = 1'b0; i_load_valid = 1'b0; i_load_x = '0; i_load_y = '0;
        repeat (3) @(negedge i_clk);
        chk("reset_ready", {15'd0, o_load_ready}, 16'd1);
        chk("reset_mbus", {11'd0, o_wen, o_wvalid, o_wlast, o_wdata_x}, 16'd0);
        chk("reset_wdata_y_sat", {13'd0, o_wdata_y, o_sat}, 16'd0);
        i_rstn = 1'b1;
        @(negedge i_clk);

        // Single frames: plain, negative, saturating, then sat-clearing zero.
        for (int v = 0; v < 4; v++) begin
            send(v, a0);
            i_load_valid = 1'b0;
            repeat (12) @(negedge i_clk);
        end

        // Valid held high across three frames.
        send(4, a0);
        send(5, a1);
        send(6, a2);
        i_load_valid = 1'b0;
        chk("frame_period_1", 16'(a1 - a0), 16'(PERIOD));
        chk("frame_period_2", 16'(a2 - a1), 16'(PERIOD));
        repeat (12) @(negedge i_clk);

        // Reset while digit 4 is on the bus.
        send(0, a0);
        i_load_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rstn = 1'b0;
        @(negedge i_clk);
        chk("midreset_mbus", {11'd0, o_wen, o_wvalid, o_wlast, o_wdata_x}, 16'd0);
        chk("midreset_wdata_y", {14'd0, o_wdata_y}, 16'd0);
        chk("midreset_ready", {15'd0, o_load_ready}, 16'd1);
        sb.delete();
        i_rstn = 1'b1;
        @(negedge i_clk);
        send(1, a0);
        i_load_valid = 1'b0;

        for (int n = 0; n < 30 && sb.size() != 0; n++) @(negedge i_clk);
        repeat (3) @(negedge i_clk);
        chk("scoreboard_drained", 16'(sb.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
